// File: rtl/dcache_store_buffer_pkg.sv
// Shared RV32I types used by the data-cache store buffer: store width encoding,
// buffered entry layout and drain FSM state.
package rv32i_types;

  typedef enum logic [2:0] {
    FUNCT3_SB = 3'b000,
    FUNCT3_SH = 3'b001,
    FUNCT3_SW = 3'b010
  } store_funct3_t;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } sbuf_entry_t;

  typedef enum logic {
    SBUF_IDLE  = 1'b0,
    SBUF_WRITE = 1'b1
  } sbuf_state_t;

endpackage

// File: rtl/dcache_store_buffer_align.sv
// Turns a raw pipeline store into a word-aligned buffer entry and flags
// stores that cannot be written as a single aligned dcache access.
module sbuf_store_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output sbuf_entry_t entry,
  output logic        misalign
);

  always_comb begin
    entry.word_addr = addr[31:2];
    entry.data      = '0;
    entry.mask      = '0;
    misalign        = 1'b0;
    case (funct3)
      FUNCT3_SB: begin
        entry.data = {4{wdata[7:0]}};
        entry.mask = 4'b0001 << addr[1:0];
      end
      FUNCT3_SH: begin
        entry.data = {2{wdata[15:0]}};
        entry.mask = 4'b0011 << addr[1:0];
        misalign   = addr[0];
      end
      FUNCT3_SW: begin
        entry.data = wdata;
        entry.mask = 4'b1111;
        misalign   = (addr[1:0] != 2'b00);
      end
      // Loads/other encodings reaching the store port are dropped as faults.
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dcache_store_buffer.sv
// In-order store buffer between the pipeline and the dcache: aligns stores,
// queues them in a small FIFO and drains one write at a time.
//
// state      | meaning
// SBUF_IDLE  | nothing being written; dcache outputs held at zero
// SBUF_WRITE | head entry presented to the dcache until dc_resp
module dcache_store_buffer
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  output logic        misalign_err,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        dc_write,
  output logic [31:0] dc_address,
  output logic [31:0] dc_wdata,
  output logic [3:0]  dc_byte_enable,
  input  logic        dc_resp,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  sbuf_state_t       state;
  sbuf_state_t       next_state;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  sbuf_entry_t       mem [DEPTH];
  sbuf_entry_t       st_entry;
  logic              st_misalign;
  logic              st_accept;
  logic              push;
  logic              pop;
  logic [DEPTH-1:0]  slot_valid;
  logic              unused_ld_offset;

  assign unused_ld_offset = ^ld_addr[1:0];

  sbuf_store_align u_align (
    .funct3   (st_funct3),
    .addr     (st_addr),
    .wdata    (st_wdata),
    .entry    (st_entry),
    .misalign (st_misalign)
  );

  // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
  assign st_ready  = (count != FULL_COUNT);
  assign st_accept = st_valid && st_ready;
  assign push      = st_accept && !st_misalign;
  assign pop       = (state == SBUF_WRITE) && dc_resp;
  assign empty     = (count == '0) && (state == SBUF_IDLE);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      SBUF_IDLE: begin
        if (count != '0) next_state = SBUF_WRITE;
      end
      SBUF_WRITE: begin
        if (dc_resp && (count_next == '0)) next_state = SBUF_IDLE;
      end
      default: next_state = SBUF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SBUF_IDLE;
      count        <= '0;
      head         <= '0;
      tail         <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= next_state;
      count        <= count_next;
      misalign_err <= st_accept && st_misalign;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
    end
  end

  // Entry storage carries no reset; validity is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= st_entry;
  end

  always_comb begin
    dc_write       = 1'b0;
    dc_address     = '0;
    dc_wdata       = '0;
    dc_byte_enable = '0;
    if (state == SBUF_WRITE) begin
      dc_write       = 1'b1;
      dc_address     = {mem[head].word_addr, 2'b00};
      dc_wdata       = mem[head].data;
      dc_byte_enable = mem[head].mask;
    end
  end

  // A slot is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid[i] = ({1'b0, PW'(i) - head} < count);
    end
  end

  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld_valid && slot_valid[i] && (mem[i].word_addr == ld_addr[31:2])) begin
        ld_hazard = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Directed self-checking bench for dcache_store_buffer (DEPTH = 4).
module tb_dcache_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic        misalign_err;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        dc_write;
  logic [31:0] dc_address;
  logic [31:0] dc_wdata;
  logic [3:0]  dc_byte_enable;
  logic        dc_resp;
  logic        empty;

  int checks = 0;
  int errors = 0;

  dcache_store_buffer #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_funct3      (st_funct3),
    .st_addr        (st_addr),
    .st_wdata       (st_wdata),
    .misalign_err   (misalign_err),
    .ld_valid       (ld_valid),
    .ld_addr        (ld_addr),
    .ld_hazard      (ld_hazard),
    .dc_write       (dc_write),
    .dc_address     (dc_address),
    .dc_wdata       (dc_wdata),
    .dc_byte_enable (dc_byte_enable),
    .dc_resp        (dc_resp),
    .empty          (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    st_valid = 1'b0; st_funct3 = 3'b000; st_addr = '0; st_wdata = '0;
    ld_valid = 1'b0; ld_addr = '0; dc_resp = 1'b0;
    #12;
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL rst_st_ready got %0b want 1", st_ready); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %0b want 1", empty); end
    checks++; if (dc_write !== 1'b0) begin errors++; $display("FAIL rst_dc_write got %0b want 0", dc_write); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign got %0b want 0", misalign_err); end
    checks++; if (dc_address !== 32'h0) begin errors++; $display("FAIL rst_dc_address got %h want 0", dc_address); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sb();
    st_valid = 1'b1; st_funct3 = 3'b000; st_addr = 32'h103; st_wdata = 32'hAB;
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    checks++; if (dc_write !== 1'b0) begin errors++; $display("FAIL sb_idle_write got %0b want 0", dc_write); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL sb_not_empty got %0b want 0", empty); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL sb_no_misalign got %0b want 0", misalign_err); end
    tick();
    @(negedge clk);
    checks++; if (dc_write !== 1'b1) begin errors++; $display("FAIL sb_write got %0b want 1", dc_write); end
    checks++; if (dc_address !== 32'h100) begin errors++; $display("FAIL sb_address got %h want 00000100", dc_address); end
    checks++; if (dc_wdata !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata got %h want abababab", dc_wdata); end
    checks++; if (dc_byte_enable !== 4'b1000) begin errors++; $display("FAIL sb_mask got %b want 1000", dc_byte_enable); end
    repeat (3) tick();
    @(negedge clk);
    checks++; if (dc_write !== 1'b1 || dc_address !== 32'h100) begin
      errors++; $display("FAIL sb_hold got write=%0b addr=%h want write=1 addr=00000100", dc_write, dc_address);
    end
    dc_resp = 1'b1;
    tick();
    dc_resp = 1'b0;
    @(negedge clk);
    checks++; if (dc_write !== 1'b0) begin errors++; $display("FAIL sb_done_write got %0b want 0", dc_write); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sb_done_empty got %0b want 1", empty); end
    checks++; if (dc_address !== 32'h0) begin errors++; $display("FAIL sb_idle_address got %h want 0", dc_address); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h14; exp_addr[1] = 32'h18; exp_addr[2] = 32'h1C; exp_addr[3] = 32'h20;
    st_valid = 1'b1; st_funct3 = 3'b010;
    for (int i = 0; i < 4; i++) begin
      st_addr = 32'h10 + 32'(4 * i);
      st_wdata = 32'hD000_0000 + 32'(i);
      tick();
    end
    st_addr = 32'h20; st_wdata = 32'hD000_0004;
    @(negedge clk);
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", st_ready); end
    tick();
    @(negedge clk);
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready_hold got %0b want 0", st_ready); end
    checks++; if (dc_write !== 1'b1 || dc_address !== 32'h10) begin
      errors++; $display("FAIL full_head got write=%0b addr=%h want write=1 addr=00000010", dc_write, dc_address);
    end
    dc_resp = 1'b1;
    tick();
    dc_resp = 1'b0;
    @(negedge clk);
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL pop_ready got %0b want 1", st_ready); end
    checks++; if (dc_address !== 32'h14) begin errors++; $display("FAIL pop_head got %h want 00000014", dc_address); end
    tick();
    st_valid = 1'b0;
    dc_resp = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL refill_ready got %0b want 0", st_ready); end
      end
      checks++; if (dc_address !== exp_addr[k] || dc_wdata !== 32'hD000_0001 + 32'(k) || dc_byte_enable !== 4'b1111) begin
        errors++; $display("FAIL drain_%0d got addr=%h data=%h be=%b want addr=%h data=%h be=1111",
                           k, dc_address, dc_wdata, dc_byte_enable, exp_addr[k], 32'hD000_0001 + 32'(k));
      end
      tick();
    end
    dc_resp = 1'b0;
    @(negedge clk);
    checks++; if (empty !== 1'b1 || dc_write !== 1'b0) begin
      errors++; $display("FAIL drain_empty got empty=%0b write=%0b want empty=1 write=0", empty, dc_write);
    end
    tick();
  endtask

  task automatic test_misalign();
    logic [2:0]  f3 [3];
    logic [31:0] ad [3];
    f3[0] = 3'b001; ad[0] = 32'h201;
    f3[1] = 3'b010; ad[1] = 32'h202;
    f3[2] = 3'b011; ad[2] = 32'h200;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_funct3 = f3[i]; st_addr = ad[i]; st_wdata = 32'h1234_5678;
      tick();
      st_valid = 1'b0;
      @(negedge clk);
      checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_pulse_%0d got %0b want 1", i, misalign_err); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL misalign_empty_%0d got %0b want 1", i, empty); end
      tick();
      @(negedge clk);
      checks++; if (misalign_err !== 1'b0 || dc_write !== 1'b0 || empty !== 1'b1) begin
        errors++; $display("FAIL misalign_after_%0d got err=%0b write=%0b empty=%0b want 0 0 1", i, misalign_err, dc_write, empty);
      end
      tick();
    end
  endtask

  task automatic test_hazard();
    st_valid = 1'b1; st_funct3 = 3'b010; st_addr = 32'h300; st_wdata = 32'hCAFE_F00D;
    tick();
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h302;
    @(negedge clk);
    checks++; if (ld_hazard !== 1'b1) begin errors++; $display("FAIL hazard_same_word got %0b want 1", ld_hazard); end
    ld_addr = 32'h304;
    #1;
    checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_next_word got %0b want 0", ld_hazard); end
    ld_valid = 1'b0; ld_addr = 32'h300;
    #1;
    checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_no_valid got %0b want 0", ld_hazard); end
    tick();
    ld_valid = 1'b1;
    @(negedge clk);
    checks++; if (ld_hazard !== 1'b1 || dc_write !== 1'b1) begin
      errors++; $display("FAIL hazard_head got hazard=%0b write=%0b want 1 1", ld_hazard, dc_write);
    end
    dc_resp = 1'b1;
    tick();
    dc_resp = 1'b0;
    @(negedge clk);
    checks++; if (ld_hazard !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL hazard_drained got hazard=%0b empty=%0b want 0 1", ld_hazard, empty);
    end
    ld_valid = 1'b0;
    tick();
  endtask

  task automatic test_push_pop();
    st_valid = 1'b1; st_funct3 = 3'b010; st_addr = 32'h400; st_wdata = 32'h0A0A_0A0A;
    tick();
    st_valid = 1'b0;
    tick();
    st_valid = 1'b1; st_funct3 = 3'b001; st_addr = 32'h406; st_wdata = 32'h7777_BEEF;
    dc_resp = 1'b1;
    @(negedge clk);
    checks++; if (dc_address !== 32'h400 || dc_wdata !== 32'h0A0A_0A0A) begin
      errors++; $display("FAIL pp_first got addr=%h data=%h want 00000400 0a0a0a0a", dc_address, dc_wdata);
    end
    tick();
    st_valid = 1'b0; dc_resp = 1'b0;
    @(negedge clk);
    checks++; if (dc_write !== 1'b1) begin errors++; $display("FAIL pp_stay_write got %0b want 1", dc_write); end
    checks++; if (dc_address !== 32'h404 || dc_wdata !== 32'hBEEF_BEEF || dc_byte_enable !== 4'b1100) begin
      errors++; $display("FAIL pp_second got addr=%h data=%h be=%b want 00000404 beefbeef 1100", dc_address, dc_wdata, dc_byte_enable);
    end
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL pp_ready got %0b want 1", st_ready); end
    dc_resp = 1'b1;
    tick();
    dc_resp = 1'b0;
    @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pp_empty got %0b want 1", empty); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    st_valid = 1'b1; st_funct3 = 3'b010; st_wdata = 32'h5555_0000;
    for (int i = 0; i < 3; i++) begin
      st_addr = 32'h500 + 32'(4 * i);
      tick();
    end
    st_valid = 1'b0;
    @(negedge clk);
    checks++; if (dc_write !== 1'b1 || empty !== 1'b0) begin
      errors++; $display("FAIL mid_pre got write=%0b empty=%0b want 1 0", dc_write, empty);
    end
    rst_n = 1'b0;
    dc_resp = 1'b1;
    #1;
    checks++; if (dc_write !== 1'b0) begin errors++; $display("FAIL mid_rst_write got %0b want 0", dc_write); end
    checks++; if (empty !== 1'b1 || st_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rst_state got empty=%0b ready=%0b want 1 1", empty, st_ready);
    end
    checks++; if (dc_address !== 32'h0) begin errors++; $display("FAIL mid_rst_address got %h want 0", dc_address); end
    tick();
    rst_n = 1'b1;
    tick();
    dc_resp = 1'b0;
    @(negedge clk);
    checks++; if (empty !== 1'b1 || dc_write !== 1'b0) begin
      errors++; $display("FAIL mid_after_resp got empty=%0b write=%0b want 1 0", empty, dc_write);
    end
    tick();
    st_valid = 1'b1; st_funct3 = 3'b000; st_addr = 32'h601; st_wdata = 32'hCDEF_005A;
    tick();
    st_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (dc_address !== 32'h600 || dc_wdata !== 32'h5A5A_5A5A || dc_byte_enable !== 4'b0010) begin
      errors++; $display("FAIL mid_restart got addr=%h data=%h be=%b want 00000600 5a5a5a5a 0010", dc_address, dc_wdata, dc_byte_enable);
    end
    dc_resp = 1'b1;
    tick();
    dc_resp = 1'b0;
    @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_final_empty got %0b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_back_to_back();
    test_misalign();
    test_hazard();
    test_push_pop();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
